// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Display-side consumer of the data memory's VGA read port. Generates VGA
// timing (640x480@60 Hz with default parameters) from the 50 MHz system
// clock, fetches the 8-bit grayscale image four pixels per 32-bit word and
// drives the DAC / connector signals.
//
// Ports:
//   clk          in   50 MHz system clock, all state on rising edge
//   rst          in   asynchronous reset, active-low
//   vga_address  out  word-aligned byte address into data memory
//   vga_rd       in   memory read data, combinational w.r.t. vga_address
//   vga_clk      out  25 MHz pixel clock (the internal tick register)
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   blank_n      out  high during the visible area
//   sync_n       out  composite sync, tied low
//   r, g, b      out  pixel colour, all equal to the grayscale byte
//   frame_start  out  one-clk pulse when the counters reach (0,0)
// ---------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] vga_address,
    input  logic [31:0] vga_rd,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] IMG_W_LIM = 10'(IMG_W);
    localparam logic [9:0] IMG_H_LIM = 10'(IMG_H);
    localparam logic [31:0] LINE_BYTES = 32'(IMG_W);

    logic       tick_q;
    logic       tick_d;
    logic [9:0] hcnt_q;
    logic [9:0] hcnt_d;
    logic [9:0] vcnt_q;
    logic [9:0] vcnt_d;
    logic       hsync_q;
    logic       hsync_d;
    logic       vsync_q;
    logic       vsync_d;
    logic       blank_n_q;
    logic       blank_n_d;
    logic [7:0] pix_q;
    logic [7:0] pix_d;
    logic       frame_start_q;
    logic       frame_start_d;

    logic       h_wrap;
    logic       v_wrap;
    logic       visible;
    logic       in_img;
    logic [7:0] lane_byte;
    logic [31:0] line_off;
    logic [31:0] word_off;

    always_comb begin
        h_wrap  = (hcnt_q == H_LAST);
        v_wrap  = (vcnt_q == V_LAST);
        visible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        in_img  = (hcnt_q < IMG_W_LIM) && (vcnt_q < IMG_H_LIM);
    end

    // Address of the word holding the current pixel; the offset is zero
    // outside the image so the port parks on BASE_ADDR.
    always_comb begin
        line_off    = 32'(vcnt_q) * LINE_BYTES;
        word_off    = {22'd0, hcnt_q[9:2], 2'b00};
        vga_address = in_img ? (BASE_ADDR + line_off + word_off) : BASE_ADDR;
    end

    // Little-endian lane select: pixel x lives in byte x mod 4 of its word.
    always_comb begin
        lane_byte = vga_rd[7:0];
        case (hcnt_q[1:0])
            2'd0:    lane_byte = vga_rd[7:0];
            2'd1:    lane_byte = vga_rd[15:8];
            2'd2:    lane_byte = vga_rd[23:16];
            default: lane_byte = vga_rd[31:24];
        endcase
    end

    // Everything except tick only moves on tick edges. The output registers
    // are loaded from the pre-increment counters, so colour and syncs both
    // describe the pixel whose address was presented during the last tick.
    always_comb begin
        tick_d        = ~tick_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_n_d     = blank_n_q;
        pix_d         = pix_q;
        frame_start_d = 1'b0;
        if (tick_q) begin
            hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
            end
            hsync_d       = ~((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
            vsync_d       = ~((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
            blank_n_d     = visible;
            pix_d         = (visible && in_img) ? lane_byte : 8'h00;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q        <= 1'b0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b0;
            pix_q         <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_clk     = tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign sync_n      = 1'b0;
    assign r           = pix_q;
    assign g           = pix_q;
    assign b           = pix_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_reader
//
// Directed bench for vga_frame_reader. Horizontal timing uses the real
// 640-pixel line; the vertical timing is shortened to a 10-line frame
// (6 visible, 1 front porch, 2 sync, 1 back porch) and the image is 256x8
// so a full frame fits in a short run. Image lines 6/7 lie in vertical
// blanking, which exposes whether blanking overrides the image window.
//
// A pixel tick happens on every even clk edge counted from reset release,
// so after edge n the counters hold position n/2 and the outputs describe
// position n/2 - 1.
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;

    logic        clk;
    logic        rst;
    logic [31:0] vga_address;
    logic [31:0] vga_rd;
    logic        vga_clk;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        sync_n;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        frame_start;
    logic        force_ff;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges;

    int hs_low, hs_first, bl_high, vs_low, vs_first, fs_cnt, fs_at;
    int vclk_err, syncn_err;

    vga_frame_reader #(
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .IMG_H    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_address (vga_address),
        .vga_rd      (vga_rd),
        .vga_clk     (vga_clk),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .sync_n      (sync_n),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Memory: a fixed word at 0x400, elsewhere distinct bytes per lane.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'h4433_2211;
        return {a[7:0] ^ 8'hC3, a[15:8] ^ 8'h3C, a[7:0] ^ 8'h5A, a[7:0]};
    endfunction

    assign vga_rd = force_ff ? 32'hFFFF_FFFF : mem_word(vga_address);

    always @(posedge clk or negedge rst) begin
        if (!rst) n_edges <= 0;
        else      n_edges <= n_edges + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pix(input string tag, input logic [7:0] exp);
        check_eq({tag, "_r"}, {24'd0, r}, {24'd0, exp});
        check_eq({tag, "_g"}, {24'd0, g}, {24'd0, exp});
        check_eq({tag, "_b"}, {24'd0, b}, {24'd0, exp});
    endtask

    task automatic clear_acc();
        hs_low = 0; hs_first = -1; bl_high = 0;
        vs_low = 0; vs_first = -1; fs_cnt = 0; fs_at = -1;
    endtask

    // Step negedge by negedge until clk edge 'target' since release has
    // happened, accumulating sync/blank statistics on the way.
    task automatic advance(input int target);
        int guard;
        guard = 0;
        while (n_edges < target && guard < 50000) begin
            @(negedge clk);
            guard++;
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = n_edges;
            end
            if (blank_n) bl_high++;
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = n_edges;
            end
            if (frame_start) begin
                fs_cnt++;
                fs_at = n_edges;
            end
            if (vga_clk !== 1'(n_edges % 2)) vclk_err++;
            if (sync_n !== 1'b0) syncn_err++;
        end
        if (n_edges < target) check_eq("advance_timeout", 32'(n_edges), 32'(target));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_vga_clk"}, {31'd0, vga_clk}, 32'd0);
        check_eq({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        check_eq({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        check_eq({tag, "_blank_n"}, {31'd0, blank_n}, 32'd0);
        check_eq({tag, "_sync_n"}, {31'd0, sync_n}, 32'd0);
        check_eq({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
        check_eq({tag, "_addr"}, vga_address, 32'h400);
        check_pix(tag, 8'h00);
    endtask

    initial begin
        rst = 1'b0;
        force_ff = 1'b0;
        vclk_err = 0;
        syncn_err = 0;
        clear_acc();
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");

        rst = 1'b1;
        check_eq("rel_addr", vga_address, 32'h400);

        advance(1);
        check_eq("first_edge_vclk", {31'd0, vga_clk}, 32'd1);
        check_eq("first_edge_blank", {31'd0, blank_n}, 32'd0);

        // Line 0, pixels 0..3 from word 0x44332211, then word 0x404.
        advance(2);
        check_pix("px0", 8'h11);
        check_eq("px0_blank", {31'd0, blank_n}, 32'd1);
        check_eq("addr_x1", vga_address, 32'h400);
        advance(4);
        check_pix("px1", 8'h22);
        check_eq("addr_x2", vga_address, 32'h400);
        advance(6);
        check_pix("px2", 8'h33);
        check_eq("addr_x3", vga_address, 32'h400);
        advance(8);
        check_pix("px3", 8'h44);
        check_eq("addr_x4", vga_address, 32'h404);
        advance(10);
        check_pix("px4", 8'h04);

        // x=300 is visible but outside the 256-wide image.
        advance(600);
        check_eq("addr_x300", vga_address, 32'h400);
        advance(602);
        check_pix("px300", 8'h00);
        check_eq("px300_blank", {31'd0, blank_n}, 32'd1);

        // End of line 0: hsync and blank widths, counter wrap.
        advance(1600);
        check_eq("hs_low_clk", 32'(hs_low), 32'd192);
        check_eq("hs_first_edge", 32'(hs_first), 32'd1314);
        check_eq("blank_high_clk", 32'(bl_high), 32'd1280);
        check_eq("no_fs_first_frame", 32'(fs_cnt), 32'd0);
        check_eq("addr_line1_x0", vga_address, 32'h500);
        clear_acc();

        advance(1604);
        check_pix("l1_px1", 8'h5A);
        advance(2110);
        check_eq("addr_l1_x255", vga_address, 32'h5FC);
        advance(2112);
        check_pix("l1_px255", 8'h3F);
        check_eq("addr_l1_x256", vga_address, 32'h400);
        advance(2114);
        check_pix("l1_px256", 8'h00);

        // Line 5 with all-ones memory: visible pixel passes, blanking masks.
        advance(8000);
        force_ff = 1'b1;
        advance(8022);
        check_pix("l5_px10_ff", 8'hFF);
        advance(9402);
        check_pix("l5_hblank_ff", 8'h00);
        check_eq("l5_hblank_blank", {31'd0, blank_n}, 32'd0);
        advance(9600);
        check_eq("addr_l6_x0", vga_address, 32'hA00);
        advance(9602);
        check_pix("l6_vblank_ff", 8'h00);
        check_eq("l6_vblank_blank", {31'd0, blank_n}, 32'd0);
        force_ff = 1'b0;

        // One full frame of samples: edges 1601..17600.
        advance(16000);
        check_eq("fs_at_frame_wrap", {31'd0, frame_start}, 32'd1);
        check_eq("addr_frame2_x0", vga_address, 32'h400);
        advance(16001);
        check_eq("fs_one_clk", {31'd0, frame_start}, 32'd0);
        advance(16002);
        check_pix("frame2_px0", 8'h11);
        advance(17600);
        check_eq("vs_low_clk", 32'(vs_low), 32'd3200);
        check_eq("vs_first_edge", 32'(vs_first), 32'd11202);
        check_eq("hs_low_frame", 32'(hs_low), 32'd1920);
        check_eq("fs_per_frame", 32'(fs_cnt), 32'd1);
        check_eq("fs_edge", 32'(fs_at), 32'd16000);

        // Mid-frame reset at (400,2) of frame 2, while vga_clk is high.
        advance(20001);
        check_eq("pre_rst_vclk", {31'd0, vga_clk}, 32'd1);
        check_eq("pre_rst_blank", {31'd0, blank_n}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_state("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        advance(2);
        check_pix("post_rst_px0", 8'h11);
        check_eq("post_rst_blank", {31'd0, blank_n}, 32'd1);
        advance(8);
        check_eq("post_rst_addr_x4", vga_address, 32'h404);

        check_eq("vga_clk_toggle_errs", 32'(vclk_err), 32'd0);
        check_eq("sync_n_errs", 32'(syncn_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
